rv32_lsu: RTL and testbench

Load/store unit sitting between the RV32I core's execute stage and port 1 (data port) of `dual_port_cache`. It accepts one load or store request at a time from the core over a valid/ready handshake. It converts the byte address and funct3 into word-addressed cache accesses with byte strobes, and returns aligned, sign- or zero-extended load data as a one-cycle response pulse. Misaligned accesses either become two sequential word accesses or are flagged as errors, depending on a compile-time option.

---
 rtl/rv32_lsu_pkg.sv | 36 +++
 rtl/lsu_load_align.sv | 30 +++
 rtl/rv32_lsu.sv | 192 +++++++++++++++++++
 tb/tb_rv32_lsu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_lsu_pkg.sv
// Shared constants and types for the rv32_lsu load/store unit.
package rv32_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input size_e size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts a 64-bit lane window right by the byte offset,
// then sign- or zero-extends the selected byte/half/word.
module lsu_load_align
  import rv32_lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] shifted;
  logic        unused_high;

  assign shifted     = data >> {off, 3'b000};
  assign unused_high = ^shifted[63:32];

  always_comb begin
    result = shifted[31:0];
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  result = {24'b0, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  result = {16'b0, shifted[15:0]};
      F3_LW:   result = shifted[31:0];
      default: result = shifted[31:0];
    endcase
  end

endmodule

// File: rtl/rv32_lsu.sv
// RV32I load/store unit in front of the cache data port.
// Define RV32_LSU_MISALIGNED_EN to split misaligned accesses into two word accesses.
module rv32_lsu
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_strobe,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [31:0]           mem_rdata
);

  state_e                state_reg, state_next;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [1:0]            off_reg;
  logic [ADDR_WIDTH-1:0] a0_reg;
  logic [31:0]           wdata_reg;
  logic                  err_reg;

  size_e                 req_size;
  logic                  req_split;
  logic                  req_illegal;
  logic                  req_err;
  logic                  accept;
  logic                  unused_addr_bits;

  logic [2:0]            nbytes;
  logic [7:0]            lanes;
  logic [63:0]           st_data;
  logic [63:0]           ld_data;
  logic [31:0]           ld_result;

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  // Request decode, evaluated on the live request while idle.
  assign req_size    = size_e'(req_funct3[1:0]);
  assign req_split   = ((req_size == SIZE_HALF) && (req_addr[1:0] == 2'b11)) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign req_illegal = req_we ? !(req_funct3 inside {F3_SB, F3_SH, F3_SW})
                              : !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
`ifdef RV32_LSU_MISALIGNED_EN
  assign req_err     = req_illegal;
`else
  assign req_err     = req_illegal | req_split;
`endif
  assign accept      = req_valid && req_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      off_reg    <= 2'b00;
      a0_reg     <= '0;
      wdata_reg  <= 32'b0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      off_reg    <= req_addr[1:0];
      a0_reg     <= req_addr[ADDR_WIDTH+1:2];
      wdata_reg  <= req_wdata;
      err_reg    <= req_err;
    end
  end

`ifdef RV32_LSU_MISALIGNED_EN
  logic        split_reg;
  logic [31:0] buf_reg;

  // Word 0 of a split load arrives during ACC1 and is held until RESP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      split_reg <= 1'b0;
      buf_reg   <= 32'b0;
    end else begin
      if (accept) begin
        split_reg <= req_split;
      end
      if (state_reg == ST_ACC1) begin
        buf_reg <= mem_rdata;
      end
    end
  end

  assign ld_data = split_reg ? {mem_rdata, buf_reg} : {32'b0, mem_rdata};
`else
  assign ld_data = {32'b0, mem_rdata};
`endif

  // Byte lanes across the two-word window starting at A0.
  assign nbytes = size_bytes(size_e'(funct3_reg[1:0]));
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign lanes[gi] = ({1'b0, off_reg} <= 3'(gi)) &&
                       (3'(gi) < ({1'b0, off_reg} + nbytes));
  end
  assign st_data = {32'b0, wdata_reg} << {off_reg, 3'b000};

  lsu_load_align u_load_align (
    .data   (ld_data),
    .off    (off_reg),
    .funct3 (funct3_reg),
    .result (ld_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = req_err ? ST_RESP : ST_ACC0;
        end
      end
`ifdef RV32_LSU_MISALIGNED_EN
      ST_ACC0: state_next = split_reg ? ST_ACC1 : ST_RESP;
      ST_ACC1: state_next = ST_RESP;
`else
      ST_ACC0: state_next = ST_RESP;
`endif
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_rdata    = 32'b0;
    mem_addr     = '0;
    mem_wdata    = 32'b0;
    mem_strobe   = 4'b0000;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = 1'b1;
      ST_ACC0: begin
        mem_addr = a0_reg;
        if (we_reg) begin
          mem_write_en = 1'b1;
          mem_strobe   = lanes[3:0];
          mem_wdata    = st_data[31:0];
        end else begin
          mem_read_en = 1'b1;
        end
      end
`ifdef RV32_LSU_MISALIGNED_EN
      ST_ACC1: begin
        mem_addr = a0_reg + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (we_reg) begin
          mem_write_en = 1'b1;
          mem_strobe   = lanes[7:4];
          mem_wdata    = st_data[63:32];
        end else begin
          mem_read_en = 1'b1;
        end
      end
`endif
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_reg;
        if (!err_reg && !we_reg) begin
          rsp_rdata = ld_result;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Directed vector bench for rv32_lsu; expectations follow RV32_LSU_MISALIGNED_EN.
module tb_rv32_lsu;

`ifdef RV32_LSU_MISALIGNED_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strobe;
  logic        mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_rdata = 32'b0;

  rv32_lsu #(.ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_strobe   (mem_strobe),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Two-word cache model: word0 lives at cur_a0, anything else returns word1.
  logic [15:0] cur_a0 = 16'h0;
  logic [31:0] cur_w0 = 32'h0;
  logic [31:0] cur_w1 = 32'h0;
  always @(posedge clk)
    mem_rdata <= mem_read_en ? ((mem_addr == cur_a0) ? cur_w0 : cur_w1) : 32'h0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
    logic        split;
    logic [15:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [3:0]  s1;
    logic [31:0] d1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] w0, input logic [31:0] w1,
                     input logic err, input logic split, input logic [15:0] a0,
                     input logic [3:0] s0, input logic [31:0] d0,
                     input logic [3:0] s1, input logic [31:0] d1,
                     input logic [31:0] rdata);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.w0 = w0; v.w1 = w1; v.err = err; v.split = split; v.a0 = a0;
    v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1; v.rdata = rdata;
    if (split && !MIS) begin
      v.err   = 1'b1;
      v.rdata = 32'h0;
    end
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    int          exp_lat;
    logic [15:0] oa[1:4];
    logic        ore[1:4];
    logic        owe[1:4];
    logic [3:0]  os[1:4];
    logic [31:0] od[1:4];
    logic        rerr;
    logic [31:0] rdat;
    logic        mem_busy;
    rerr = 1'bx; rdat = 'x; mem_busy = 1'bx;
    cur_a0 = v.a0; cur_w0 = v.w0; cur_w1 = v.w1;
    @(negedge clk);
    check({v.name, " ready"}, 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    // Junk on the request bus while busy must be ignored.
    req_we = ~v.we; req_funct3 = v.f3 ^ 3'b011;
    req_addr = ~v.addr; req_wdata = ~v.wdata;
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      oa[c] = mem_addr; ore[c] = mem_read_en; owe[c] = mem_write_en;
      os[c] = mem_strobe; od[c] = mem_wdata;
      if (rsp_valid) begin
        lat = c; rerr = rsp_err; rdat = rsp_rdata;
        mem_busy = |{mem_addr, mem_wdata, mem_strobe, mem_write_en, mem_read_en};
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
    exp_lat = v.err ? 1 : (v.split ? 3 : 2);
    check({v.name, " latency"}, 32'(lat), 32'(exp_lat));
    check({v.name, " rsp_err"}, 32'(rerr), 32'(v.err));
    check({v.name, " rsp_rdata"}, rdat, v.rdata);
    check({v.name, " mem idle in resp"}, 32'(mem_busy), 32'h0);
    if (!v.err) begin
      check({v.name, " acc0 addr"}, 32'(oa[1]), 32'(v.a0));
      check({v.name, " acc0 re/we"}, {30'b0, ore[1], owe[1]}, {30'b0, ~v.we, v.we});
      if (v.we) begin
        check({v.name, " acc0 strobe"}, 32'(os[1]), 32'(v.s0));
        check({v.name, " acc0 wdata"}, od[1], v.d0);
      end
      if (v.split) begin
        check({v.name, " acc1 addr"}, 32'(oa[2]), 32'(v.a0 + 16'h1));
        check({v.name, " acc1 re/we"}, {30'b0, ore[2], owe[2]}, {30'b0, ~v.we, v.we});
        if (v.we) begin
          check({v.name, " acc1 strobe"}, 32'(os[2]), 32'(v.s1));
          check({v.name, " acc1 wdata"}, od[2], v.d1);
        end
      end
    end
    @(negedge clk);
    check({v.name, " rsp pulse end"}, {30'b0, rsp_valid, req_ready}, 32'h1);
    $display("vec %-12s we=%0d f3=%03b addr=%08h lat=%0d err=%0d rdata=%08h",
             v.name, v.we, v.f3, v.addr, lat, rerr, rdat);
  endtask

  function automatic logic [31:0] out_bits();
    return 32'(|{rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata,
                 mem_strobe, mem_write_en, mem_read_en});
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    //   name        we   f3      addr          wdata         w0            w1            err  split a0       s0       d0            s1       d1            rdata
    add("lw_al",     0, 3'b010, 32'h0000_48D0, 32'h0,        32'hDEADBEEF, 32'h0BAD0BAD, 0, 0, 16'h1234, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'hDEADBEEF);
    add("lb_off3",   0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF80);
    add("lbu_off3",  0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h00000080);
    add("lh_off2",   0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'hFFFF80FF);
    add("lhu_off2",  0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h000080FF);
    add("lb_off1",   0, 3'b000, 32'h0000_0101, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0000007F);
    add("lh_off1",   0, 3'b001, 32'h0000_0105, 32'h0,        32'h80FF7F01, 32'h0BAD0BAD, 0, 0, 16'h0041, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'hFFFFFF7F);
    add("sb_off2",   1, 3'b000, 32'h0000_0202, 32'h000000AB, 32'h0,        32'h0,        0, 0, 16'h0080, 4'b0100, 32'h00AB0000, 4'b0000, 32'h0,        32'h0);
    add("sh_off2",   1, 3'b001, 32'h0000_0202, 32'h00001234, 32'h0,        32'h0,        0, 0, 16'h0080, 4'b1100, 32'h12340000, 4'b0000, 32'h0,        32'h0);
    add("sw_al",     1, 3'b010, 32'h0000_0010, 32'hA5A55A5A, 32'h0,        32'h0,        0, 0, 16'h0004, 4'b1111, 32'hA5A55A5A, 4'b0000, 32'h0,        32'h0);
    add("ld_f3_011", 0, 3'b011, 32'h0000_0020, 32'h0,        32'h12345678, 32'h0,        1, 0, 16'h0008, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("st_f3_100", 1, 3'b100, 32'h0000_0020, 32'h12345678, 32'h0,        32'h0,        1, 0, 16'h0008, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h0);
    add("lw_split",  0, 3'b010, 32'h0000_0101, 32'h0,        32'h44332211, 32'h88776655, 0, 1, 16'h0040, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'h55443322);
    add("sw_split",  1, 3'b010, 32'h0000_0203, 32'hCAFEBABE, 32'h0,        32'h0,        0, 1, 16'h0080, 4'b1000, 32'hBE000000, 4'b0111, 32'h00CAFEBA, 32'h0);
    add("sh_split",  1, 3'b001, 32'h0000_0207, 32'h0000BEEF, 32'h0,        32'h0,        0, 1, 16'h0081, 4'b1000, 32'hEF000000, 4'b0001, 32'h000000BE, 32'h0);
    add("lh_wrap",   0, 3'b001, 32'hABC3_FFFF, 32'h0,        32'h11223344, 32'h55667788, 0, 1, 16'hFFFF, 4'b0000, 32'h0,        4'b0000, 32'h0,        32'hFFFF8811);

    #1;
    check("reset ready", 32'(req_ready), 32'h1);
    check("reset outputs", out_bits(), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during ACC0 drops the request without a response.
    cur_a0 = 16'h0011; cur_w0 = 32'h13572468; cur_w1 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0044;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst acc0 read_en", 32'(mem_read_en), 32'h1);
    resetn = 1'b0;
    #1;
    check("rst mid ready", 32'(req_ready), 32'h1);
    check("rst mid outputs", out_bits(), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("rst no response", 32'(seen), 32'h0);
    $display("reset-in-acc0 sequence: responses seen=%0d", seen);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
